// File: rtl/pong_game_sequencer.sv
// Pong match controller: IDLE/SERVE/PLAY/OVER sequencing, game-step strobes
// derived from the frame tick, serve delay and score keeping.
module pong_game_sequencer #(
    parameter int STEP_DIV     = 2,
    parameter int SERVE_FRAMES = 60,
    parameter int WIN_SCORE    = 7,
    parameter int SCORE_W      = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               frame_tick,
    input  logic               start_btn,
    input  logic               player_point,
    input  logic               opp_point,
    output logic               step,
    output logic               ball_center,
    output logic               serve_dir,
    output logic [SCORE_W-1:0] player_score,
    output logic [SCORE_W-1:0] opp_score,
    output logic [1:0]         state,
    output logic               game_over
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SERVE = 2'd1;
    localparam logic [1:0] ST_PLAY  = 2'd2;
    localparam logic [1:0] ST_OVER  = 2'd3;

    localparam int DIV_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam int SRV_W = (SERVE_FRAMES > 1) ? $clog2(SERVE_FRAMES) : 1;

    localparam logic [DIV_W-1:0]   DIV_LAST = DIV_W'(STEP_DIV - 1);
    localparam logic [SRV_W-1:0]   SRV_LAST = SRV_W'(SERVE_FRAMES - 1);
    localparam logic [SCORE_W-1:0] WIN      = SCORE_W'(WIN_SCORE);

    logic [1:0]         state_q, state_d;
    logic [SCORE_W-1:0] player_score_q, player_score_d;
    logic [SCORE_W-1:0] opp_score_q, opp_score_d;
    logic               step_q, step_d;
    logic               ball_center_q, ball_center_d;
    logic               serve_dir_q, serve_dir_d;
    logic               game_over_q, game_over_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic [SRV_W-1:0]   serve_cnt_q, serve_cnt_d;
    logic               start_prev_q, start_prev_d;

    logic               start_edge;
    logic [SCORE_W-1:0] player_score_inc;
    logic [SCORE_W-1:0] opp_score_inc;

    always_comb begin
        start_edge       = start_btn & ~start_prev_q;
        player_score_inc = (player_point && player_score_q != WIN) ?
                           player_score_q + 1'b1 : player_score_q;
        opp_score_inc    = (opp_point && opp_score_q != WIN) ?
                           opp_score_q + 1'b1 : opp_score_q;

        state_d        = state_q;
        player_score_d = player_score_q;
        opp_score_d    = opp_score_q;
        step_d         = 1'b0;
        ball_center_d  = 1'b0;
        serve_dir_d    = serve_dir_q;
        div_d          = div_q;
        serve_cnt_d    = serve_cnt_q;
        start_prev_d   = start_btn;

        case (state_q)
            ST_IDLE, ST_OVER: begin
                if (start_edge) begin
                    state_d        = ST_SERVE;
                    player_score_d = '0;
                    opp_score_d    = '0;
                    serve_dir_d    = 1'b1;
                    ball_center_d  = 1'b1;
                    serve_cnt_d    = '0;
                end
            end
            ST_SERVE: begin
                if (frame_tick) begin
                    if (serve_cnt_q == SRV_LAST) begin
                        state_d     = ST_PLAY;
                        serve_cnt_d = '0;
                        div_d       = '0;
                    end else begin
                        serve_cnt_d = serve_cnt_q + 1'b1;
                    end
                end
            end
            ST_PLAY: begin
                // A point takes priority over a step falling on the same tick.
                if (player_point || opp_point) begin
                    player_score_d = player_score_inc;
                    opp_score_d    = opp_score_inc;
                    if (player_point && !opp_point) begin
                        serve_dir_d = 1'b0;
                    end else if (opp_point && !player_point) begin
                        serve_dir_d = 1'b1;
                    end
                    if (player_score_inc == WIN || opp_score_inc == WIN) begin
                        state_d = ST_OVER;
                    end else begin
                        state_d       = ST_SERVE;
                        serve_cnt_d   = '0;
                        ball_center_d = 1'b1;
                    end
                end else if (frame_tick) begin
                    if (div_q == DIV_LAST) begin
                        div_d  = '0;
                        step_d = 1'b1;
                    end else begin
                        div_d = div_q + 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        game_over_d = (state_d == ST_OVER);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            player_score_q <= '0;
            opp_score_q    <= '0;
            step_q         <= 1'b0;
            ball_center_q  <= 1'b0;
            serve_dir_q    <= 1'b1;
            game_over_q    <= 1'b0;
            div_q          <= '0;
            serve_cnt_q    <= '0;
            start_prev_q   <= 1'b0;
        end else begin
            state_q        <= state_d;
            player_score_q <= player_score_d;
            opp_score_q    <= opp_score_d;
            step_q         <= step_d;
            ball_center_q  <= ball_center_d;
            serve_dir_q    <= serve_dir_d;
            game_over_q    <= game_over_d;
            div_q          <= div_d;
            serve_cnt_q    <= serve_cnt_d;
            start_prev_q   <= start_prev_d;
        end
    end

    assign step         = step_q;
    assign ball_center  = ball_center_q;
    assign serve_dir    = serve_dir_q;
    assign player_score = player_score_q;
    assign opp_score    = opp_score_q;
    assign state        = state_q;
    assign game_over    = game_over_q;

endmodule

// File: tb/tb_pong_game_sequencer.sv
// Bench for pong_game_sequencer: match-level reference model checked every
// cycle, plus directed scenarios with literal expectations.
module tb_pong_game_sequencer;

    localparam int STEP_DIV     = 2;
    localparam int SERVE_FRAMES = 4;
    localparam int WIN_SCORE    = 3;
    localparam int SCORE_W      = 4;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               frame_tick = 1'b0;
    logic               start_btn = 1'b0;
    logic               player_point = 1'b0;
    logic               opp_point = 1'b0;
    logic               step;
    logic               ball_center;
    logic               serve_dir;
    logic [SCORE_W-1:0] player_score;
    logic [SCORE_W-1:0] opp_score;
    logic [1:0]         state;
    logic               game_over;

    int n_checks = 0;
    int n_fail   = 0;

    pong_game_sequencer #(
        .STEP_DIV    (STEP_DIV),
        .SERVE_FRAMES(SERVE_FRAMES),
        .WIN_SCORE   (WIN_SCORE),
        .SCORE_W     (SCORE_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .frame_tick  (frame_tick),
        .start_btn   (start_btn),
        .player_point(player_point),
        .opp_point   (opp_point),
        .step        (step),
        .ball_center (ball_center),
        .serve_dir   (serve_dir),
        .player_score(player_score),
        .opp_score   (opp_score),
        .state       (state),
        .game_over   (game_over)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    // Match-level model: phase names, tick counts since entering a phase.
    int m_phase;        // 0 idle, 1 serve, 2 play, 3 over
    int m_ps, m_os;
    int m_dir, m_step, m_bc;
    int m_btn_prev;
    int m_serve_ticks, m_play_ticks;

    always @(posedge clk or negedge rst_n) begin
        int ph, ps, os, dir, stp, bc, st, pt;
        if (!rst_n) begin
            m_phase <= 0; m_ps <= 0; m_os <= 0; m_dir <= 1;
            m_step <= 0; m_bc <= 0; m_btn_prev <= 0;
            m_serve_ticks <= 0; m_play_ticks <= 0;
        end else begin
            ph = m_phase; ps = m_ps; os = m_os; dir = m_dir;
            st = m_serve_ticks; pt = m_play_ticks; stp = 0; bc = 0;
            if (ph == 0 || ph == 3) begin
                if (start_btn && m_btn_prev == 0) begin
                    ph = 1; ps = 0; os = 0; dir = 1; bc = 1; st = 0;
                end
            end else if (ph == 1) begin
                if (frame_tick) begin
                    st = st + 1;
                    if (st == SERVE_FRAMES) begin ph = 2; pt = 0; end
                end
            end else begin
                if (player_point || opp_point) begin
                    if (player_point && ps < WIN_SCORE) ps = ps + 1;
                    if (opp_point && os < WIN_SCORE) os = os + 1;
                    if (player_point && !opp_point) dir = 0;
                    if (opp_point && !player_point) dir = 1;
                    if (ps == WIN_SCORE || os == WIN_SCORE) ph = 3;
                    else begin ph = 1; st = 0; bc = 1; end
                end else if (frame_tick) begin
                    pt = pt + 1;
                    if (pt % STEP_DIV == 0) stp = 1;
                end
            end
            m_phase <= ph; m_ps <= ps; m_os <= os; m_dir <= dir;
            m_step <= stp; m_bc <= bc; m_btn_prev <= int'(start_btn);
            m_serve_ticks <= st; m_play_ticks <= pt;
        end
    end

    always @(negedge clk) begin
        chk("model_state", int'(state), m_phase);
        chk("model_player_score", int'(player_score), m_ps);
        chk("model_opp_score", int'(opp_score), m_os);
        chk("model_serve_dir", int'(serve_dir), m_dir);
        chk("model_step", int'(step), m_step);
        chk("model_ball_center", int'(ball_center), m_bc);
        chk("model_game_over", int'(game_over), (m_phase == 3) ? 1 : 0);
    end

    // One clock cycle with the given inputs; returns at negedge+1.
    task automatic cyc(input logic f, input logic b, input logic pp, input logic op);
        frame_tick = f; start_btn = b; player_point = pp; opp_point = op;
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic serve_out(input logic b);
        for (int i = 0; i < SERVE_FRAMES; i++) begin
            cyc(1'b1, b, 1'b0, 1'b0);
            cyc(1'b0, b, 1'b0, 1'b0);
        end
    endtask

    int steps_seen;

    initial begin
        repeat (3) @(negedge clk);
        #1 rst_n = 1'b1;
        chk("reset_state", int'(state), 0);
        chk("reset_serve_dir", int'(serve_dir), 1);

        // 1: start edge
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        chk("t1_state", int'(state), 1);
        chk("t1_ball_center", int'(ball_center), 1);
        chk("t1_scores", int'(player_score) + int'(opp_score), 0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        chk("t1_ball_center_drop", int'(ball_center), 0);

        // 2: serve delay then step cadence
        for (int i = 1; i <= SERVE_FRAMES; i++) begin
            cyc(1'b1, 1'b0, 1'b0, 1'b0);
            chk("t2_serve_state", int'(state), (i == SERVE_FRAMES) ? 2 : 1);
            chk("t2_serve_no_step", int'(step), 0);
            cyc(1'b0, 1'b0, 1'b0, 1'b0);
        end
        steps_seen = 0;
        for (int i = 1; i <= 6; i++) begin
            cyc(1'b1, 1'b0, 1'b0, 1'b0);
            chk("t2_step_after_tick", int'(step), (i % 2 == 0) ? 1 : 0);
            steps_seen += int'(step);
            cyc(1'b0, 1'b0, 1'b0, 1'b0);
            chk("t2_step_one_cycle", int'(step), 0);
        end
        chk("t2_step_count", steps_seen, 3);

        // 3: player point, then opp point ignored during serve
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        chk("t3_player_score", int'(player_score), 1);
        chk("t3_serve_dir", int'(serve_dir), 0);
        chk("t3_state", int'(state), 1);
        chk("t3_ball_center", int'(ball_center), 1);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        chk("t3_opp_ignored", int'(opp_score), 0);
        serve_out(1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        chk("t3_opp_score", int'(opp_score), 1);
        chk("t3_opp_dir", int'(serve_dir), 1);
        serve_out(1'b0);
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        serve_out(1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        chk("t3_score_2_2", int'(player_score) * 16 + int'(opp_score), 2 * 16 + 2);
        serve_out(1'b0);

        // 4: simultaneous points at 2/2 on the step tick
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b1, 1'b1);
        chk("t4_player_score", int'(player_score), 3);
        chk("t4_opp_score", int'(opp_score), 3);
        chk("t4_state", int'(state), 3);
        chk("t4_game_over", int'(game_over), 1);
        chk("t4_serve_dir", int'(serve_dir), 1);
        chk("t4_no_ball_center", int'(ball_center), 0);
        chk("t4_no_step", int'(step), 0);
        cyc(1'b1, 1'b0, 1'b1, 1'b0);
        chk("t4_frozen", int'(player_score), 3);

        // 5: restart from OVER, held button, restart in PLAY ignored
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        chk("t5_state", int'(state), 1);
        chk("t5_scores", int'(player_score) + int'(opp_score), 0);
        chk("t5_game_over", int'(game_over), 0);
        chk("t5_ball_center", int'(ball_center), 1);
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        chk("t5_held_no_edge", int'(ball_center), 0);
        serve_out(1'b1);
        chk("t5_in_play", int'(state), 2);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        chk("t5_play_restart_ignored", int'(state), 2);
        chk("t5_play_no_center", int'(ball_center), 0);

        // 6: asynchronous reset mid-play with non-reset values present
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        serve_out(1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        chk("t6_pre_dir", int'(serve_dir), 0);
        #1 rst_n = 1'b0;
        #1;
        chk("t6_state", int'(state), 0);
        chk("t6_player_score", int'(player_score), 0);
        chk("t6_opp_score", int'(opp_score), 0);
        chk("t6_step", int'(step), 0);
        chk("t6_ball_center", int'(ball_center), 0);
        chk("t6_serve_dir", int'(serve_dir), 1);
        chk("t6_game_over", int'(game_over), 0);
        @(negedge clk);
        #1 rst_n = 1'b1;
        cyc(1'b1, 1'b1, 1'b0, 1'b0);
        chk("t6_restart_state", int'(state), 1);
        for (int i = 1; i < SERVE_FRAMES; i++) cyc(1'b1, 1'b1, 1'b0, 1'b0);
        chk("t6_tick_with_edge_not_counted", int'(state), 1);
        cyc(1'b1, 1'b1, 1'b0, 1'b0);
        chk("t6_play_after_serve", int'(state), 2);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
